// File: rtl/rr_stream_mux.sv
// N-to-1 valid/ready stream multiplexer with round-robin arbitration and packet locking.
// Output beats are registered and tagged with their source channel in y_sel.
module rr_stream_mux #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] x_data,
   input  logic [N-1:0]       x_valid,
   input  logic [N-1:0]       x_last,
   output logic [N-1:0]       x_ready,
   output logic [WIDTH-1:0]   y_data,
   output logic [SEL_W-1:0]   y_sel,
   output logic               y_last,
   output logic               y_valid,
   input  logic               y_ready
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   cur, cur_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;

   logic               can_load_c;
   logic               grant_found_c;
   logic [SEL_W-1:0]   grant_c;
   logic [31:0]        idx_c;
   logic [SEL_W-1:0]   sel_c;
   logic [WIDTH-1:0]   beat_c;
   logic               load_c;

   logic [WIDTH-1:0]   y_data_nxt;
   logic [SEL_W-1:0]   y_sel_nxt;
   logic               y_last_nxt;
   logic               y_valid_nxt;

   assign can_load_c = ~y_valid | y_ready;

   // First valid channel after ptr, wrapping modulo N
   always_comb begin
      grant_found_c = 1'b0;
      grant_c       = '0;
      idx_c         = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx_c = (32'(ptr) + k) % N;
         if (!grant_found_c && x_valid[idx_c[SEL_W-1:0]]) begin
            grant_found_c = 1'b1;
            grant_c       = idx_c[SEL_W-1:0];
         end
      end
   end

   // A locked packet keeps its channel; otherwise the arbiter picks
   assign sel_c = (state == LOCKED) ? cur : grant_c;

   always_comb begin
      beat_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (SEL_W'(i) == sel_c) beat_c = x_data[i*WIDTH +: WIDTH];
      end
   end

   // Next-state, accept and output-register load logic
   always_comb begin
      state_nxt   = state;
      cur_nxt     = cur;
      ptr_nxt     = ptr;
      x_ready     = '0;
      load_c      = 1'b0;
      y_data_nxt  = y_data;
      y_sel_nxt   = y_sel;
      y_last_nxt  = y_last;
      y_valid_nxt = y_valid & ~y_ready;

      case (state)
         IDLE: begin
            if (can_load_c && grant_found_c) begin
               x_ready[grant_c] = 1'b1;
               load_c           = 1'b1;
               ptr_nxt          = grant_c;
               cur_nxt          = grant_c;
               if (!x_last[grant_c]) state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            x_ready[cur] = can_load_c;
            if (can_load_c && x_valid[cur]) begin
               load_c = 1'b1;
               if (x_last[cur]) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (load_c) begin
         y_data_nxt  = beat_c;
         y_sel_nxt   = sel_c;
         y_last_nxt  = x_last[sel_c];
         y_valid_nxt = 1'b1;
      end

      if (rst) x_ready = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cur     <= '0;
         ptr     <= SEL_W'(N - 1);
         y_data  <= '0;
         y_sel   <= '0;
         y_last  <= 1'b0;
         y_valid <= 1'b0;
      end else begin
         state   <= state_nxt;
         cur     <= cur_nxt;
         ptr     <= ptr_nxt;
         y_data  <= y_data_nxt;
         y_sel   <= y_sel_nxt;
         y_last  <= y_last_nxt;
         y_valid <= y_valid_nxt;
      end
   end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed vector table plus random soak, checked against
// an independent arbitration model feeding an expected-beat queue.
module tb_rr_stream_mux;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned N     = 4;
   localparam int unsigned SEL_W = 2;

   logic               clk;
   logic               rst;
   logic [N*WIDTH-1:0] x_data;
   logic [N-1:0]       x_valid;
   logic [N-1:0]       x_last;
   logic [N-1:0]       x_ready;
   logic [WIDTH-1:0]   y_data;
   logic [SEL_W-1:0]   y_sel;
   logic               y_last;
   logic               y_valid;
   logic               y_ready;

   rr_stream_mux #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst),
      .x_data(x_data), .x_valid(x_valid), .x_last(x_last), .x_ready(x_ready),
      .y_data(y_data), .y_sel(y_sel), .y_last(y_last), .y_valid(y_valid),
      .y_ready(y_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-channel sources: data = base + beat count, last every plen beats
   logic [7:0] base [N] = '{8'h00, 8'h5A, 8'h20, 8'h30};
   int cnt  [N];
   int plen [N];

   task automatic drive_src();
      for (int i = 0; i < N; i++) begin
         x_data[i*WIDTH +: WIDTH] = base[i] + 8'(cnt[i]);
         x_last[i] = ((cnt[i] % plen[i]) == (plen[i] - 1));
      end
   endtask

   // Call right after a negedge: note accepts, cross the edge, advance sources
   task automatic advance();
      logic [N-1:0] acc;
      acc = x_valid & x_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) cnt[i]++;
      drive_src();
   endtask

   // Reference model and scoreboard
   typedef struct packed {
      logic [7:0] d;
      logic [1:0] s;
      logic       l;
   } beat_t;

   beat_t q[$];
   int    m_ptr = N - 1;
   int    m_cur = 0;
   bit    m_locked = 1'b0;
   bit    m_yv = 1'b0;
   bit    mon_en = 1'b0;

   always @(negedge clk) begin : model
      logic [N-1:0] exp_xr;
      int    g;
      bit    acc;
      bit    can;
      beat_t b;
      exp_xr = '0;
      g      = -1;
      acc    = 1'b0;
      can    = !m_yv || y_ready;
      if (!rst) begin
         if (m_locked) begin
            g = m_cur;
            exp_xr[g] = can;
            acc = can && x_valid[g];
         end else begin
            for (int k = 1; k <= N; k++)
               if (g < 0 && x_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0 && can) begin
               exp_xr[g] = 1'b1;
               acc = 1'b1;
            end
         end
      end
      if (mon_en) begin
         check("model x_ready", 32'(x_ready), 32'(exp_xr));
         check("model y_valid", 32'(y_valid), 32'(m_yv));
         if (m_yv) begin
            if (q.size() == 0) check("model queue nonempty", 32'(0), 32'(1));
            else check("model beat {data,sel,last}", 32'({y_data, y_sel, y_last}), 32'(q[0]));
         end
      end
      if (rst) begin
         m_ptr = N - 1; m_cur = 0; m_locked = 1'b0; m_yv = 1'b0;
         q.delete();
      end else begin
         if (m_yv && y_ready) void'(q.pop_front());
         if (acc) begin
            b.d = x_data[g*WIDTH +: WIDTH];
            b.s = 2'(g);
            b.l = x_last[g];
            q.push_back(b);
            m_ptr = g; m_cur = g; m_locked = !x_last[g]; m_yv = 1'b1;
         end else if (y_ready) begin
            m_yv = 1'b0;
         end
      end
   end

   // Upstream protocol: data/last held while a valid beat waits
   logic [N*WIDTH-1:0] p_data;
   logic [N-1:0]       p_last;
   logic [N-1:0]       p_hold = '0;
   always @(negedge clk) begin
      for (int i = 0; i < N; i++)
         if (p_hold[i] && x_valid[i])
            assert (x_data[i*WIDTH +: WIDTH] == p_data[i*WIDTH +: WIDTH] && x_last[i] == p_last[i])
               else $error("FAIL protocol ch%0d changed while stalled", i);
      p_hold = x_valid & ~x_ready & {N{~rst}};
      p_data = x_data;
      p_last = x_last;
   end

   // Vector table
   typedef struct {
      bit         clr;
      logic [7:0] plen;
      bit         rst;
      logic [3:0] valid;
      bit         yr;
      logic [3:0] xr;
      bit         yv;
      logic [1:0] sel;
      logic [7:0] data;
      bit         last;
      bit         zero;
   } row_t;

   row_t       rows[$];
   bit         pend_clr = 1'b0;
   logic [7:0] pend_plen = 8'h55;

   task automatic clr_next(input logic [7:0] pl);
      pend_clr  = 1'b1;
      pend_plen = pl;
   endtask

   task automatic add(input bit r, input logic [3:0] v, input bit yr, input logic [3:0] xr,
                      input bit yv, input logic [1:0] s, input logic [7:0] d, input bit l,
                      input bit z);
      row_t w;
      w.clr = pend_clr; w.plen = pend_plen; w.rst = r; w.valid = v; w.yr = yr; w.xr = xr;
      w.yv = yv; w.sel = s; w.data = d; w.last = l; w.zero = z;
      rows.push_back(w);
      pend_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; x_valid = '1; y_ready = 1'b1;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; plen[i] = 1; end
      drive_src();

      // Rotation 0,1,2,3,0 with single-beat packets
      clr_next(8'h55);
      add(0, 4'b1111, 1, 4'b0001, 0, 0, 8'h00, 0, 0);
      add(0, 4'b1111, 1, 4'b0010, 1, 0, 8'h00, 1, 0);
      add(0, 4'b1111, 1, 4'b0100, 1, 1, 8'h5A, 1, 0);
      add(0, 4'b1111, 1, 4'b1000, 1, 2, 8'h20, 1, 0);
      add(0, 4'b1111, 1, 4'b0001, 1, 3, 8'h30, 1, 0);
      add(0, 4'b1111, 1, 4'b0010, 1, 0, 8'h01, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 1, 1, 8'h5B, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0, 0);
      // Channel 2 three-beat packet while channel 0 waits
      clr_next(8'h75);
      add(0, 4'b0101, 1, 4'b0100, 0, 0, 8'h00, 0, 0);
      add(0, 4'b0101, 1, 4'b0100, 1, 2, 8'h20, 0, 0);
      add(0, 4'b0101, 1, 4'b0100, 1, 2, 8'h21, 0, 0);
      add(0, 4'b0101, 1, 4'b0001, 1, 2, 8'h22, 1, 0);
      add(0, 4'b0001, 1, 4'b0001, 1, 0, 8'h00, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 1, 0, 8'h01, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0, 0);
      // Backpressure: 0x5A held for 4 cycles, then no-bubble drain
      clr_next(8'h55);
      add(0, 4'b0010, 1, 4'b0010, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 4'b0110, 0, 4'b0000, 1, 1, 8'h5A, 1, 0);
      add(0, 4'b0110, 1, 4'b0100, 1, 1, 8'h5A, 1, 0);
      add(0, 4'b0110, 1, 4'b0010, 1, 2, 8'h20, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 1, 1, 8'h5B, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0, 0);
      // Pointer wrap from channel 3 to channel 0
      clr_next(8'h55);
      add(0, 4'b1000, 1, 4'b1000, 0, 0, 8'h00, 0, 0);
      add(0, 4'b1001, 1, 4'b0001, 1, 3, 8'h30, 1, 0);
      add(0, 4'b1001, 1, 4'b1000, 1, 0, 8'h00, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 1, 3, 8'h31, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0, 0);
      // Locked stall on channel 1 while channel 3 waits
      clr_next(8'h5D);
      add(0, 4'b0010, 1, 4'b0010, 0, 0, 8'h00, 0, 0);
      add(0, 4'b1010, 1, 4'b0010, 1, 1, 8'h5A, 0, 0);
      add(0, 4'b1000, 1, 4'b0010, 1, 1, 8'h5B, 0, 0);
      add(0, 4'b1000, 1, 4'b0010, 0, 0, 8'h00, 0, 0);
      add(0, 4'b1010, 1, 4'b0010, 0, 0, 8'h00, 0, 0);
      add(0, 4'b1000, 1, 4'b1000, 1, 1, 8'h5C, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 1, 3, 8'h30, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0, 0);
      // Reset mid-packet, then arbitration restarts at channel 0
      clr_next(8'h5D);
      add(0, 4'b0010, 1, 4'b0010, 0, 0, 8'h00, 0, 0);
      add(1, 4'b0010, 1, 4'b0000, 1, 1, 8'h5A, 0, 0);
      add(0, 4'b1111, 1, 4'b0001, 0, 0, 8'h00, 0, 1);
      add(0, 4'b0000, 1, 4'b0000, 1, 0, 8'h00, 1, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 0, 0);

      // Reset state with all channels requesting
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(negedge clk);
      check("reset x_ready", 32'(x_ready), 32'(0));
      check("reset y_valid", 32'(y_valid), 32'(0));
      check("reset y_sel", 32'(y_sel), 32'(0));
      check("reset y_data", 32'(y_data), 32'(0));
      check("reset y_last", 32'(y_last), 32'(0));
      advance();

      foreach (rows[k]) begin
         if (rows[k].clr) begin
            for (int i = 0; i < N; i++) begin
               cnt[i]  = 0;
               plen[i] = int'(rows[k].plen[2*i +: 2]);
            end
            drive_src();
         end
         rst = rows[k].rst; x_valid = rows[k].valid; y_ready = rows[k].yr;
         @(negedge clk);
         check($sformatf("row%0d x_ready", k), 32'(x_ready), 32'(rows[k].xr));
         check($sformatf("row%0d y_valid", k), 32'(y_valid), 32'(rows[k].yv));
         if (rows[k].yv) begin
            check($sformatf("row%0d y_sel", k), 32'(y_sel), 32'(rows[k].sel));
            check($sformatf("row%0d y_data", k), 32'(y_data), 32'(rows[k].data));
            check($sformatf("row%0d y_last", k), 32'(y_last), 32'(rows[k].last));
         end
         if (rows[k].zero)
            check($sformatf("row%0d y_zero", k), 32'({y_data, y_sel, y_last}), 32'(0));
         advance();
      end

      // Random soak: random valids, packet lengths and backpressure
      for (int i = 0; i < N; i++) begin
         cnt[i]  = 0;
         plen[i] = int'($urandom_range(1, 3));
      end
      drive_src();
      for (int c = 0; c < 400; c++) begin
         x_valid = 4'($urandom);
         y_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         advance();
      end
      x_valid = '0;
      y_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         advance();
      end
      check("drain queue empty", 32'(q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
